// File: rtl/cmd_frame_driver.sv
// rtl/cmd_frame_driver.sv - command frame player/checker for the cmd_parser byte interface
// Define CMD_DRV_GAP_EN to insert GAP_CYCLES idle cycles between sent bytes.
`timescale 1ns/1ps
module cmd_frame_driver #(
  parameter int MAX_TX_BYTES   = 64,
  parameter int MAX_RX_BYTES   = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [MAX_TX_BYTES*8-1:0]         tx_frame,
  input  logic [$clog2(MAX_TX_BYTES+1)-1:0] tx_len,
  input  logic [$clog2(MAX_RX_BYTES+1)-1:0] rx_len,
  input  logic [MAX_RX_BYTES*8-1:0]         expect_frame,
  output logic [7:0]                        rxd_data,
  output logic                              rxd_data_ready,
  input  logic                              txd_start,
  input  logic [7:0]                        txd_data,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              timeout,
  output logic [MAX_RX_BYTES*8-1:0]         rx_frame,
  output logic [$clog2(MAX_RX_BYTES+1)-1:0] rx_count
);

  localparam int TXW = $clog2(MAX_TX_BYTES + 1);
  localparam int RXW = $clog2(MAX_RX_BYTES + 1);
  localparam int TXI = (MAX_TX_BYTES > 1) ? $clog2(MAX_TX_BYTES) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES < 2 || GAP_CYCLES < 0) begin : g_bad_params
    $error("cmd_frame_driver: TIMEOUT_CYCLES must be >= 2 and GAP_CYCLES >= 0");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_WAIT_RX = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [7:0]                tx_mem [MAX_TX_BYTES];
  logic [7:0]                rx_mem [MAX_RX_BYTES];
  logic [MAX_RX_BYTES*8-1:0] exp_q;
  logic [TXW-1:0]            tx_len_q, tx_len_clamp, tx_idx;
  logic [RXW-1:0]            rx_len_q, rx_len_clamp;
  logic [TCW-1:0]            tmo_cnt;
  logic                      accept, send_more, gap_hold, rx_full, tmo_hit, frame_match;

  assign tx_len_clamp = (tx_len > TXW'(MAX_TX_BYTES)) ? TXW'(MAX_TX_BYTES) : tx_len;
  assign rx_len_clamp = (rx_len > RXW'(MAX_RX_BYTES)) ? RXW'(MAX_RX_BYTES) : rx_len;

  // Responses are kept from the first SEND cycle, so bytes overlapping the send are not lost.
  assign accept    = ((state_q == S_SEND) || (state_q == S_WAIT_RX)) && txd_start &&
                     (rx_count < rx_len_q);
  assign send_more = (tx_idx < tx_len_q);
  assign rx_full   = (rx_count == rx_len_q);
  // Fires on the idle cycle that would carry the counter to TIMEOUT_CYCLES-1.
  assign tmo_hit   = (tmo_cnt == TCW'(TIMEOUT_CYCLES - 2));

  assign busy = (state_q == S_SEND) || (state_q == S_WAIT_RX);
  assign done = (state_q == S_FINISH);

`ifdef CMD_DRV_GAP_EN
  localparam int GW = $clog2(GAP_CYCLES + 2);
  logic [GW-1:0] gap_cnt;

  assign gap_hold = (gap_cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (state_q == S_IDLE) begin
      gap_cnt <= (start && (tx_len_clamp != '0)) ? GW'(GAP_CYCLES) : '0;
    end else if (state_q == S_SEND) begin
      if (send_more && !gap_hold) begin
        gap_cnt <= GW'(GAP_CYCLES);
      end else if (gap_hold) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end else begin
      gap_cnt <= '0;
    end
  end
`else
  assign gap_hold = 1'b0;
`endif

  always_comb begin
    frame_match = 1'b1;
    for (int i = 0; i < MAX_RX_BYTES; i++) begin
      if ((RXW'(i) < rx_len_q) && (rx_mem[i] != exp_q[(MAX_RX_BYTES-1-i)*8 +: 8])) begin
        frame_match = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (tx_len_clamp != '0) ? S_SEND : S_WAIT_RX;
        end
      end
      S_SEND: begin
        if (!send_more) begin
          state_d = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
        if (rx_full || (!accept && tmo_hit)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_len_q       <= '0;
      rx_len_q       <= '0;
      exp_q          <= '0;
      tx_idx         <= '0;
      tmo_cnt        <= '0;
      rx_count       <= '0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      rxd_data       <= '0;
      rxd_data_ready <= 1'b0;
      for (int i = 0; i < MAX_TX_BYTES; i++) tx_mem[i] <= '0;
      for (int i = 0; i < MAX_RX_BYTES; i++) rx_mem[i] <= '0;
    end else begin
      rxd_data       <= '0;
      rxd_data_ready <= 1'b0;
      if (state_q != S_WAIT_RX) begin
        tmo_cnt <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            tx_len_q <= tx_len_clamp;
            rx_len_q <= rx_len_clamp;
            exp_q    <= expect_frame;
            for (int i = 0; i < MAX_TX_BYTES; i++) begin
              tx_mem[i] <= tx_frame[(MAX_TX_BYTES-1-i)*8 +: 8];
            end
            for (int i = 0; i < MAX_RX_BYTES; i++) rx_mem[i] <= '0;
            rx_count <= '0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            tx_idx   <= TXW'(1);
            // Byte 0 goes out straight from the port so it lands on the cycle after start.
            if (tx_len_clamp != '0) begin
              rxd_data       <= tx_frame[MAX_TX_BYTES*8-1 -: 8];
              rxd_data_ready <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (send_more && !gap_hold) begin
            rxd_data       <= tx_mem[tx_idx[TXI-1:0]];
            rxd_data_ready <= 1'b1;
            tx_idx         <= tx_idx + TXW'(1);
          end
        end
        S_WAIT_RX: begin
          if (rx_full) begin
            pass <= frame_match;
          end else if (accept) begin
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TCW'(1);
          end
        end
        default: ;
      endcase

      if (accept) begin
        for (int i = 0; i < MAX_RX_BYTES; i++) begin
          if (rx_count == RXW'(i)) rx_mem[i] <= txd_data;
        end
        rx_count <= rx_count + RXW'(1);
      end
    end
  end

  for (genvar g = 0; g < MAX_RX_BYTES; g++) begin : g_rx_pack
    assign rx_frame[(MAX_RX_BYTES-1-g)*8 +: 8] = rx_mem[g];
  end

endmodule

// File: tb/tb_cmd_frame_driver.sv
// tb/tb_cmd_frame_driver.sv - scoreboard bench for cmd_frame_driver
`timescale 1ns/1ps
module tb_cmd_frame_driver;

  localparam int MAXTX = 64;
  localparam int MAXRX = 32;
  localparam int TMO   = 16;
  localparam int W     = MAXRX * 8;
`ifdef CMD_DRV_GAP_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 0;
`endif
  localparam int STRIDE = GAP + 1;

  logic                           clk;
  logic                           reset;
  logic                           start;
  logic [MAXTX*8-1:0]             tx_frame;
  logic [$clog2(MAXTX+1)-1:0]     tx_len;
  logic [$clog2(MAXRX+1)-1:0]     rx_len;
  logic [MAXRX*8-1:0]             expect_frame;
  logic [7:0]                     rxd_data;
  logic                           rxd_data_ready;
  logic                           txd_start;
  logic [7:0]                     txd_data;
  logic                           busy, done, pass, timeout;
  logic [MAXRX*8-1:0]             rx_frame;
  logic [$clog2(MAXRX+1)-1:0]     rx_count;

  cmd_frame_driver #(
    .MAX_TX_BYTES(MAXTX), .MAX_RX_BYTES(MAXRX), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tx_frame(tx_frame), .tx_len(tx_len),
    .rx_len(rx_len), .expect_frame(expect_frame), .rxd_data(rxd_data),
    .rxd_data_ready(rxd_data_ready), .txd_start(txd_start), .txd_data(txd_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .rx_frame(rx_frame),
    .rx_count(rx_count)
  );

  typedef struct { logic [7:0] data; int cyc; } tx_exp_t;
  typedef struct { logic ok; logic tmo; int cnt; logic [W-1:0] frame; int cyc; } done_exp_t;

  tx_exp_t   tx_q[$];
  done_exp_t done_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, run_s = 0, tx_seen = 0, done_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a done pulse.
  initial begin
    tx_exp_t   t;
    done_exp_t d;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rxd_data_ready) begin
          tx_seen++;
          if (tx_q.size() == 0) begin
            chk("unexpected rxd_data_ready", W'(rxd_data), W'(0));
          end else begin
            t = tx_q.pop_front();
            chk("rxd_data", W'(rxd_data), W'(t.data));
            chk("rxd cycle", W'(cyc), W'(t.cyc));
          end
        end
        if (done) begin
          done_seen++;
          if (done_q.size() == 0) begin
            chk("unexpected done", W'(done), W'(0));
          end else begin
            d = done_q.pop_front();
            chk("pass", W'(pass), W'(d.ok));
            chk("timeout", W'(timeout), W'(d.tmo));
            chk("rx_count", W'(rx_count), W'(d.cnt));
            chk("rx_frame", rx_frame, d.frame);
            chk("busy at done", W'(busy), W'(0));
            if (d.cyc >= 0) chk("done cycle", W'(cyc), W'(d.cyc));
          end
        end
      end
    end
  end

  task automatic fire();
    run_s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_tx(input int n);
    for (int i = 0; i < n; i++) begin
      tx_q.push_back('{data: tx_frame[(MAXTX-1-i)*8 +: 8], cyc: cyc + 1 + i*STRIDE});
    end
  endtask

  task automatic respond(input logic [7:0] b);
    txd_start = 1'b1;
    txd_data  = b;
    tick();
    txd_start = 1'b0;
    txd_data  = '0;
    tick();
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin
      tick();
      n++;
    end
    if (done_seen < target) chk("done wait expired", W'(done_seen), W'(target));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " busy"}, W'(busy), W'(0));
    chk({tag, " done"}, W'(done), W'(0));
    chk({tag, " pass"}, W'(pass), W'(0));
    chk({tag, " timeout"}, W'(timeout), W'(0));
    chk({tag, " rx_count"}, W'(rx_count), W'(0));
    chk({tag, " rx_frame"}, rx_frame, W'(0));
    chk({tag, " rxd_data"}, W'(rxd_data), W'(0));
    chk({tag, " rxd_data_ready"}, W'(rxd_data_ready), W'(0));
  endtask

  task automatic load_long();
    tx_frame = '0;
    tx_frame[(MAXTX-1)*8 +: 8] = 8'h02;
    tx_frame[(MAXTX-2)*8 +: 8] = 8'h00;
    tx_frame[(MAXTX-3)*8 +: 8] = 8'h33;
    for (int i = 3; i < 54; i++) tx_frame[(MAXTX-1-i)*8 +: 8] = 8'h61 + 8'((i - 3) % 26);
    tx_len = 54;
    rx_len = 0;
    expect_frame = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] exp;
    int base;
    reset = 1'b1; start = 1'b0; tx_frame = '0; tx_len = '0; rx_len = '0;
    expect_frame = '0; txd_start = 1'b0; txd_data = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #2 reset = 1'b1;
    tick();

    // Countdown: 10..1 returned, 11th byte must be ignored.
    tx_frame = '0; tx_frame[(MAXTX-1)*8 +: 8] = 8'h04; tx_len = 1; rx_len = 10;
    exp = '0;
    for (int i = 0; i < 10; i++) exp[(MAXRX-1-i)*8 +: 8] = 8'(10 - i);
    expect_frame = exp;
    push_tx(1);
    done_q.push_back('{ok: 1'b1, tmo: 1'b0, cnt: 10, frame: exp, cyc: -1});
    fire();
    tick(); tick();
    for (int k = 0; k < 11; k++) respond((k < 10) ? 8'(10 - k) : 8'hEE);
    wait_done(1, 100);

    // Mismatch: 4th byte returned as 0x09.
    push_tx(1);
    exp[(MAXRX-4)*8 +: 8] = 8'h09;
    done_q.push_back('{ok: 1'b0, tmo: 1'b0, cnt: 10, frame: exp, cyc: -1});
    fire();
    tick();
    for (int k = 0; k < 10; k++) respond((k == 3) ? 8'h09 : 8'(10 - k));
    wait_done(2, 100);
    tick();

    // Timeout: 17 bytes sent, parser silent.
    tx_frame = '0; tx_frame[(MAXTX-1)*8 +: 8] = 8'h01;
    for (int i = 1; i < 17; i++) tx_frame[(MAXTX-1-i)*8 +: 8] = 8'hA0 + 8'(i);
    tx_len = 17; rx_len = 1; expect_frame = '0; expect_frame[W-1 -: 8] = 8'h55;
    push_tx(17);
    done_q.push_back('{ok: 1'b0, tmo: 1'b1, cnt: 0, frame: '0, cyc: cyc + 1 + 16*STRIDE + TMO});
    fire();
    wait_done(3, 300);
    tick();

    // Byte on the timeout threshold cycle counts as a byte.
    tx_frame = '0; tx_frame[(MAXTX-1)*8 +: 8] = 8'h11; tx_len = 1; rx_len = 1;
    exp = '0; exp[W-1 -: 8] = 8'h5A; expect_frame = exp;
    push_tx(1);
    done_q.push_back('{ok: 1'b1, tmo: 1'b0, cnt: 1, frame: exp, cyc: cyc + 18});
    fire();
    repeat (15) tick();
    respond(8'h5A);
    wait_done(4, 100);
    tick();

    // Empty run with repeated start pulses while busy and on done.
    tx_frame = '0; tx_len = 0; rx_len = 0; expect_frame = '0;
    done_q.push_back('{ok: 1'b1, tmo: 1'b0, cnt: 0, frame: '0, cyc: cyc + 2});
    run_s = cyc;
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    repeat (10) tick();
    chk("empty run done count", W'(done_seen), W'(5));

    // Long frame; inputs scrambled after start must not matter.
    load_long();
    base = tx_seen;
    push_tx(54);
    done_q.push_back('{ok: 1'b1, tmo: 1'b0, cnt: 0, frame: '0, cyc: cyc + 1 + 53*STRIDE + 2});
    fire();
    tx_frame = '0; tx_len = 0;
    wait_done(6, 400);
    chk("long frame byte count", W'(tx_seen - base), W'(54));
    tick();

    // Reset while byte 20 is on the bus.
    load_long();
    base = tx_seen;
    push_tx(20);
    fire();
    for (int n = 0; n < 300 && tx_seen < base + 20; n++) tick();
    chk("bytes before reset", W'(tx_seen - base), W'(20));
    reset = 1'b0;
    @(negedge clk);
    check_cleared("abort");
    tick(); tick();
    reset = 1'b1;
    repeat (100) tick();
    chk("no done after abort", W'(done_seen), W'(6));

    chk("tx scoreboard drained", W'(tx_q.size()), W'(0));
    chk("done scoreboard drained", W'(done_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
